// File: rtl/bcd_timer_pkg.sv
// ---------------------------------------------------------------------------
// bcd_timer_pkg
// Shared definitions for the BCD timer and its seven-segment scanner:
//   SEG_BLANK     - all segments off (active-low), dp off
//   GLYPH_0..9    - 7-bit active-low glyphs, bit 0 = segment a .. bit 6 = g
//   bcd_to_seg()  - BCD digit to glyph; non-BCD codes render blank
//   timer_mode_t  - count direction
// ---------------------------------------------------------------------------
package bcd_timer_pkg;

    localparam logic [7:0] SEG_BLANK = 8'hFF;

    localparam logic [6:0] GLYPH_0   = 7'h40;
    localparam logic [6:0] GLYPH_1   = 7'h79;
    localparam logic [6:0] GLYPH_2   = 7'h24;
    localparam logic [6:0] GLYPH_3   = 7'h30;
    localparam logic [6:0] GLYPH_4   = 7'h19;
    localparam logic [6:0] GLYPH_5   = 7'h12;
    localparam logic [6:0] GLYPH_6   = 7'h02;
    localparam logic [6:0] GLYPH_7   = 7'h78;
    localparam logic [6:0] GLYPH_8   = 7'h00;
    localparam logic [6:0] GLYPH_9   = 7'h10;
    localparam logic [6:0] GLYPH_OFF = 7'h7F;

    typedef enum logic {
        MODE_UP   = 1'b0,
        MODE_DOWN = 1'b1
    } timer_mode_t;

    function automatic logic [6:0] bcd_to_seg(input logic [3:0] digit);
        logic [6:0] glyph;
        case (digit)
            4'd0:    glyph = GLYPH_0;
            4'd1:    glyph = GLYPH_1;
            4'd2:    glyph = GLYPH_2;
            4'd3:    glyph = GLYPH_3;
            4'd4:    glyph = GLYPH_4;
            4'd5:    glyph = GLYPH_5;
            4'd6:    glyph = GLYPH_6;
            4'd7:    glyph = GLYPH_7;
            4'd8:    glyph = GLYPH_8;
            4'd9:    glyph = GLYPH_9;
            default: glyph = GLYPH_OFF;
        endcase
        return glyph;
    endfunction

endpackage

// File: rtl/bcd_timer_display_ssd_scanner.sv
// ---------------------------------------------------------------------------
// ssd_scanner
// Time-multiplexed seven-segment scanner. Each digit is shown for SCAN_DIV
// clocks, then the index advances 0..NUM_DIGITS-1 and wraps. Outputs are
// registered (one cycle behind index/count).
// Optional build macro: LEADING_ZERO_BLANK_EN blanks enabled digits above
// the most-significant nonzero digit (digit 0 always shown).
// Ports:
//   clk      - system clock
//   rst      - synchronous active-high reset
//   count    - BCD value to show, digit 0 in [3:0]
//   digit_en - 1 = digit shown
//   anode    - active-low digit select
//   segment  - active-low segments, [0]=a .. [6]=g, [7]=dp
// ---------------------------------------------------------------------------
module ssd_scanner
    import bcd_timer_pkg::*;
#(
    parameter int unsigned              NUM_DIGITS = 4,
    parameter int unsigned              SCAN_DIV   = 100000,
    parameter logic [NUM_DIGITS-1:0]    DP_MASK    = NUM_DIGITS'(4'b0100)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [4*NUM_DIGITS-1:0]     count,
    input  logic [NUM_DIGITS-1:0]       digit_en,
    output logic [NUM_DIGITS-1:0]       anode,
    output logic [7:0]                  segment
);

    localparam int unsigned SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DIGITS - 1);

    logic [SW-1:0]          scan_q;
    logic [IW-1:0]          idx_q;
    logic [NUM_DIGITS-1:0]  anode_q, anode_d;
    logic [7:0]             segment_q, segment_d;
    logic [3:0]             digit_val;
    logic                   shown;

    always_comb begin
        digit_val = count[{idx_q, 2'b00} +: 4];
        shown     = digit_en[idx_q];
`ifdef LEADING_ZERO_BLANK_EN
        // Blank when this digit and every higher one are zero.
        if ((idx_q != '0) && ((count >> {idx_q, 2'b00}) == '0)) begin
            shown = 1'b0;
        end
`endif
        if (shown) begin
            anode_d   = ~(NUM_DIGITS'(1) << idx_q);
            segment_d = {~DP_MASK[idx_q], bcd_to_seg(digit_val)};
        end else begin
            anode_d   = '1;
            segment_d = SEG_BLANK;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            scan_q    <= '0;
            idx_q     <= '0;
            anode_q   <= '1;
            segment_q <= SEG_BLANK;
        end else begin
            anode_q   <= anode_d;
            segment_q <= segment_d;
            if (scan_q == SCAN_LAST) begin
                scan_q <= '0;
                idx_q  <= (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
            end else begin
                scan_q <= scan_q + 1'b1;
            end
        end
    end

    assign anode   = anode_q;
    assign segment = segment_q;

endmodule

// File: rtl/bcd_timer_display.sv
// ---------------------------------------------------------------------------
// bcd_timer_display
// N-digit BCD up/down timer with preset load and done flag, driving a
// multiplexed seven-segment display through ssd_scanner.
// Optional build macro: LEADING_ZERO_BLANK_EN (see ssd_scanner).
// Ports:
//   clk      - system clock
//   btnc     - synchronous active-high reset
//   run      - 1 = prescaler/counting active, 0 = paused
//   mode     - 0 = count up, 1 = count down
//   load     - single-cycle pulse, loads preset (nibbles >9 clamp to 9)
//   preset   - BCD preset, digit 0 in [3:0]
//   digit_en - 1 = digit shown
//   count    - current BCD value
//   done     - countdown reached zero; cleared only by load or reset
//   anode    - active-low digit select
//   segment  - active-low segments, [0]=a .. [6]=g, [7]=dp
// ---------------------------------------------------------------------------
module bcd_timer_display
    import bcd_timer_pkg::*;
#(
    parameter int unsigned              NUM_DIGITS = 4,
    parameter int unsigned              TICK_DIV   = 1000000,
    parameter int unsigned              SCAN_DIV   = 100000,
    parameter logic [NUM_DIGITS-1:0]    DP_MASK    = NUM_DIGITS'(4'b0100)
) (
    input  logic                        clk,
    input  logic                        btnc,
    input  logic                        run,
    input  logic                        mode,
    input  logic                        load,
    input  logic [4*NUM_DIGITS-1:0]     preset,
    input  logic [NUM_DIGITS-1:0]       digit_en,
    output logic [4*NUM_DIGITS-1:0]     count,
    output logic                        done,
    output logic [NUM_DIGITS-1:0]       anode,
    output logic [7:0]                  segment
);

    localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

    logic [PW-1:0]              presc_q;
    logic [4*NUM_DIGITS-1:0]    count_q;
    logic                       done_q;

    logic [4*NUM_DIGITS-1:0]    count_inc, count_dec, preset_sat;
    logic                       carry, borrow, tick, count_zero;
    timer_mode_t                dir;

    assign dir        = timer_mode_t'(mode);
    assign tick       = run && (presc_q == PRESC_LAST);
    assign count_zero = (count_q == '0);

    // Ripple BCD increment/decrement; all-9s wraps to zero on increment.
    always_comb begin
        count_inc = count_q;
        count_dec = count_q;
        carry     = 1'b1;
        borrow    = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (carry) begin
                if (count_q[4*i +: 4] >= 4'd9) begin
                    count_inc[4*i +: 4] = 4'd0;
                end else begin
                    count_inc[4*i +: 4] = count_q[4*i +: 4] + 4'd1;
                    carry               = 1'b0;
                end
            end
            if (borrow) begin
                if (count_q[4*i +: 4] == 4'd0) begin
                    count_dec[4*i +: 4] = 4'd9;
                end else begin
                    count_dec[4*i +: 4] = count_q[4*i +: 4] - 4'd1;
                    borrow              = 1'b0;
                end
            end
        end
    end

    always_comb begin
        preset_sat = preset;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (preset[4*i +: 4] > 4'd9) begin
                preset_sat[4*i +: 4] = 4'd9;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (btnc) begin
            presc_q <= '0;
            count_q <= '0;
            done_q  <= 1'b0;
        end else if (load) begin
            presc_q <= '0;
            count_q <= preset_sat;
            done_q  <= 1'b0;
        end else if (run) begin
            if (tick) begin
                presc_q <= '0;
                if (dir == MODE_UP) begin
                    count_q <= count_inc;
                end else if (count_zero) begin
                    done_q <= 1'b1;
                end else begin
                    count_q <= count_dec;
                    if (count_dec == '0) begin
                        done_q <= 1'b1;
                    end
                end
            end else begin
                presc_q <= presc_q + 1'b1;
            end
        end
    end

    assign count = count_q;
    assign done  = done_q;

    ssd_scanner #(
        .NUM_DIGITS (NUM_DIGITS),
        .SCAN_DIV   (SCAN_DIV),
        .DP_MASK    (DP_MASK)
    ) u_scanner (
        .clk      (clk),
        .rst      (btnc),
        .count    (count_q),
        .digit_en (digit_en),
        .anode    (anode),
        .segment  (segment)
    );

endmodule

// File: tb/tb_bcd_timer_display.sv
// ---------------------------------------------------------------------------
// tb_bcd_timer_display
// Self-checking bench: a decimal-arithmetic model of the timer and display
// is compared with the DUT every cycle, plus hand-computed literal checks
// for the directed scenarios, then a randomized run.
// ---------------------------------------------------------------------------
module tb_bcd_timer_display;

    localparam int N  = 4;
    localparam int TD = 4;
    localparam int SD = 2;
    localparam logic [3:0] DPM = 4'b0100;

    logic        clk = 1'b0;
    logic        btnc, run, mode, load;
    logic [15:0] preset;
    logic [3:0]  digit_en;
    logic [15:0] count;
    logic        done;
    logic [3:0]  anode;
    logic [7:0]  segment;

    always #5 clk = ~clk;

    bcd_timer_display #(
        .NUM_DIGITS (N),
        .TICK_DIV   (TD),
        .SCAN_DIV   (SD),
        .DP_MASK    (DPM)
    ) dut (
        .clk      (clk),
        .btnc     (btnc),
        .run      (run),
        .mode     (mode),
        .load     (load),
        .preset   (preset),
        .digit_en (digit_en),
        .count    (count),
        .done     (done),
        .anode    (anode),
        .segment  (segment)
    );

    // Lit segments, active-high, bit 0 = a .. bit 6 = g.
    logic [6:0] lit_hi [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
    int pw10 [5] = '{1, 10, 100, 1000, 10000};

    // Model state: value kept as a plain decimal integer.
    int          m_val;
    bit          m_done;
    int          m_presc;
    longint      m_scan;
    logic [3:0]  m_anode;
    logic [7:0]  m_seg;
    int          m_idx, m_dig;
    bit          m_show;

    int n_checks = 0;
    int n_pass   = 0;
    bit chk_en   = 1'b0;

    function automatic int sat_val(logic [15:0] p);
        int v = 0;
        for (int i = N - 1; i >= 0; i--) begin
            int d = int'(p[4*i +: 4]);
            if (d > 9) d = 9;
            v = v * 10 + d;
        end
        return v;
    endfunction

    function automatic logic [15:0] to_bcd(int v);
        logic [15:0] r = '0;
        for (int i = 0; i < N; i++) begin
            r[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    always @(posedge clk) begin
        if (btnc) begin
            m_val = 0; m_done = 0; m_presc = 0; m_scan = 0;
            m_anode = 4'hF; m_seg = 8'hFF;
        end else begin
            // Display registers reflect the pre-edge index and value.
            m_idx  = int'((m_scan / SD) % N);
            m_show = digit_en[m_idx];
`ifdef LEADING_ZERO_BLANK_EN
            if (m_idx > 0 && m_val < pw10[m_idx]) m_show = 0;
`endif
            m_dig = (m_val / pw10[m_idx]) % 10;
            if (m_show) begin
                m_anode = 4'hF & ~(4'b0001 << m_idx);
                m_seg   = {~DPM[m_idx], ~lit_hi[m_dig]};
            end else begin
                m_anode = 4'hF;
                m_seg   = 8'hFF;
            end
            m_scan++;
            if (load) begin
                m_val = sat_val(preset); m_presc = 0; m_done = 0;
            end else if (run) begin
                if (m_presc == TD - 1) begin
                    m_presc = 0;
                    if (!mode) begin
                        m_val = (m_val + 1) % pw10[N];
                    end else if (m_val == 0) begin
                        m_done = 1;
                    end else begin
                        m_val--;
                        if (m_val == 0) m_done = 1;
                    end
                end else begin
                    m_presc++;
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // Compare at negedge, then return #1 after the next posedge for driving.
    task automatic adv();
        @(negedge clk);
        if (chk_en) begin
            check("count", 32'(count), 32'(to_bcd(m_val)));
            check("done", 32'(done), 32'(m_done));
            check("anode", 32'(anode), 32'(m_anode));
            check("segment", 32'(segment), 32'(m_seg));
        end
        @(posedge clk);
        #1;
    endtask

    logic [3:0] a_seq [8];
    logic [7:0] s_seq [8];
    logic [3:0] a_exp [8] = '{4'hE, 4'hE, 4'hD, 4'hD, 4'hB, 4'hB, 4'h7, 4'h7};
    logic [15:0] cd_cnt [4] = '{16'h0002, 16'h0001, 16'h0000, 16'h0000};
    bit          cd_done [4] = '{1'b0, 1'b0, 1'b1, 1'b1};

    initial begin
        int g;
        int nf;
        btnc = 1; run = 0; mode = 0; load = 0; preset = '0; digit_en = 4'hF;
        adv();
        chk_en = 1;
        adv();
        adv();
        check("rst_anode", 32'(anode), 32'h0000000F);
        check("rst_segment", 32'(segment), 32'h000000FF);
        check("rst_count", 32'(count), 32'h0);
        check("rst_done", 32'(done), 32'h0);
        btnc = 0;

        // Count up for 40 cycles: 10 ticks.
        run = 1;
        repeat (40) adv();
        run = 0;
        check("up_40", 32'(count), 32'h0010);

        // Wrap from all nines.
        preset = 16'h9999; load = 1; run = 1;
        adv();
        load = 0;
        check("load_9999", 32'(count), 32'h9999);
        repeat (3) adv();
        check("pre_wrap", 32'(count), 32'h9999);
        adv();
        check("wrap_count", 32'(count), 32'h0000);
        check("wrap_done", 32'(done), 32'h0);

        // Countdown from 3 through zero and one hold tick.
        preset = 16'h0003; mode = 1; load = 1;
        adv();
        load = 0;
        for (int k = 0; k < 4; k++) begin
            repeat (4) adv();
            check("cd_count", 32'(count), 32'(cd_cnt[k]));
            check("cd_done", 32'(done), 32'(cd_done[k]));
        end

        // Load on the tick cycle wins and restarts the prescaler.
        mode = 0;
        g = 0;
        while (m_presc != TD - 1 && g < 10) begin adv(); g++; end
        preset = 16'h0500; load = 1;
        adv();
        load = 0;
        check("coll_count", 32'(count), 32'h0500);
        check("coll_done", 32'(done), 32'h0);
        repeat (3) adv();
        check("coll_hold", 32'(count), 32'h0500);
        adv();
        check("coll_tick", 32'(count), 32'h0501);

        // Scan sequence with 1234.
        run = 0; preset = 16'h1234; load = 1;
        adv();
        load = 0;
        adv(); adv();
        g = 0;
        while (anode == 4'hE && g < 8) begin adv(); g++; end
        while (anode != 4'hE && g < 16) begin adv(); g++; end
        check("scan_sync", 32'(anode), 32'hE);
        for (int i = 0; i < 8; i++) begin
            a_seq[i] = anode; s_seq[i] = segment;
            adv();
        end
        for (int i = 0; i < 8; i++) check("scan_anode", 32'(a_seq[i]), 32'(a_exp[i]));
        check("seg_d0", 32'(s_seq[0]), 32'h99);
        check("seg_d1", 32'(s_seq[2]), 32'hB0);
        check("seg_d2", 32'(s_seq[4]), 32'h24);
        check("seg_d3", 32'(s_seq[6]), 32'hF9);

        // Disabled digit 0 shows as blank slot.
        digit_en = 4'hE;
        adv(); adv();
        nf = 0;
        for (int i = 0; i < 8; i++) begin
            if (anode == 4'hF) begin
                nf++;
                check("en_blank_seg", 32'(segment), 32'hFF);
            end
            adv();
        end
        check("en_blank_slots", 32'(nf), 32'd2);
        digit_en = 4'hF;

        // Pause keeps the prescaler fraction.
        run = 1;
        g = 0;
        while (m_presc != 2 && g < 10) begin adv(); g++; end
        run = 0;
        repeat (20) adv();
        run = 1;
        adv();
        check("pause_hold", 32'(count), 32'h1234);
        adv();
        check("pause_resume", 32'(count), 32'h1235);

        // Leading-zero slots.
        run = 0; preset = 16'h0042; load = 1;
        adv();
        load = 0;
        adv(); adv();
        nf = 0;
        for (int i = 0; i < 8; i++) begin
            if (anode == 4'hF) nf++;
            adv();
        end
`ifdef LEADING_ZERO_BLANK_EN
        check("lzb_slots", 32'(nf), 32'd4);
`else
        check("lzb_slots", 32'(nf), 32'd0);
`endif

        // Randomized run against the model.
        repeat (3000) begin
            btnc   = ($urandom_range(0, 199) == 0);
            run    = ($urandom_range(0, 3) != 0);
            mode   = 1'($urandom_range(0, 1));
            load   = ($urandom_range(0, 15) == 0);
            preset = 16'($urandom);
            if ($urandom_range(0, 31) == 0) digit_en = 4'($urandom);
            adv();
        end
        btnc = 0; run = 0; load = 0;
        adv();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
